// File: rtl/decoder_sync_pkg.sv
// decoder_sync_pkg: shared encodings and defaults for the decoder sync controller
package decoder_sync_pkg;
    localparam int SYNC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE = 2'b00, SEARCH = 2'b01, VERIFY = 2'b10, LOCK = 2'b11} state_t;
    typedef struct packed {
        logic swap;
        logic inv;
    } hyp_t;
endpackage

// File: rtl/decoder_sync_ctrl_if.sv
// decoder_sync_ctrl_if: serial bit stream from the decoder and swap/invert controls back to it
interface decoder_sync_ctrl_if;
    logic bit_en;
    logic bit_in;
    logic swap;
    logic data_inv;
    modport master (output bit_en, bit_in, input swap, data_inv);
    modport slave (input bit_en, bit_in, output swap, data_inv);
endinterface

// File: rtl/decoder_sync_ctrl_correlator.sv
// sync_correlator: serial shift register with masked error-count compare against the sync word
module sync_correlator #(
    parameter int SYNC_W = 32
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic              clear,
    input  logic [SYNC_W-1:0] sync_word,
    input  logic [SYNC_W-1:0] sync_mask,
    input  logic [2:0]        max_err,
    output logic              hit,
    output logic              fill_done
);
    localparam int FW = $clog2(SYNC_W);
    localparam int EW = $clog2(SYNC_W + 1);
    logic [SYNC_W-1:0] sr, sr_next;
    logic [FW-1:0] fill;
    logic [EW-1:0] errs;
    assign sr_next = {sr[SYNC_W-2:0], bit_in};
    assign errs = EW'($countones((sr_next ^ sync_word) & sync_mask));
    assign hit = errs <= EW'(max_err);
    // fill saturates one short of SYNC_W so the bit being shifted completes the window
    assign fill_done = fill == FW'(SYNC_W - 1);
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            sr <= '0;
            fill <= '0;
        end else begin
            if (bit_en) sr <= sr_next;
            if (clear) fill <= '0;
            else if (bit_en && !fill_done) fill <= fill + FW'(1);
        end
    end
endmodule

// File: rtl/decoder_sync_ctrl.sv
// decoder_sync_ctrl: searches swap/invert hypotheses until the sync word recurs, then locks with flywheel
module decoder_sync_ctrl
    import decoder_sync_pkg::*;
#(
    parameter int SYNC_W = SYNC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rs,
    decoder_sync_ctrl_if.slave  dec,
    input  logic                ctrl_en,
    input  logic [SYNC_W-1:0]   sync_word,
    input  logic [SYNC_W-1:0]   sync_mask,
    input  logic [2:0]          max_err,
    input  logic [CNT_W-1:0]    frame_len,
    input  logic [CNT_W-1:0]    search_limit,
    input  logic [3:0]          verify_n,
    input  logic [3:0]          flywheel_n,
    output logic                locked,
    output logic                frame_strobe,
    output logic [1:0]          state
);
    state_t st, st_n;
    hyp_t hyp, hyp_n;
    logic [CNT_W-1:0] cnt, cnt_n, flen;
    logic [3:0] hits, hits_n, hits_inc, misses, misses_n, misses_inc, vn, fn;
    logic strobe_n, clear, hit, fill_done, hv, check;
    sync_correlator #(.SYNC_W(SYNC_W)) u_corr (
        .clk(clk),
        .rs(rs),
        .bit_en(dec.bit_en),
        .bit_in(dec.bit_in),
        .clear(clear),
        .sync_word(sync_word),
        .sync_mask(sync_mask),
        .max_err(max_err),
        .hit(hit),
        .fill_done(fill_done)
    );
    assign flen = frame_len < CNT_W'(SYNC_W) ? CNT_W'(SYNC_W) : frame_len;
    assign vn = verify_n == 4'd0 ? 4'd1 : verify_n;
    assign fn = flywheel_n == 4'd0 ? 4'd1 : flywheel_n;
    assign check = cnt == flen - CNT_W'(1);
    assign hv = hit & fill_done;
    assign hits_inc = hits + 4'd1;
    assign misses_inc = misses + 4'd1;
    assign dec.swap = hyp.swap;
    assign dec.data_inv = hyp.inv;
    assign locked = st == LOCK;
    assign state = st;
    always_comb begin
        st_n = st;
        hyp_n = hyp;
        cnt_n = cnt;
        hits_n = hits;
        misses_n = misses;
        strobe_n = 1'b0;
        clear = 1'b0;
        if (!ctrl_en) begin
            st_n = IDLE;
            cnt_n = '0;
            hits_n = '0;
            misses_n = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_n = SEARCH;
                    cnt_n = '0;
                    hits_n = '0;
                    misses_n = '0;
                    clear = 1'b1;
                end
                SEARCH: if (dec.bit_en) begin
                    if (hv) begin
                        st_n = VERIFY;
                        hits_n = 4'd1;
                        cnt_n = '0;
                    end else if (search_limit != '0 && cnt >= search_limit - CNT_W'(1)) begin
                        hyp_n = hyp_t'(hyp + 2'd1);
                        cnt_n = '0;
                        clear = 1'b1;
                    end else cnt_n = cnt + CNT_W'(1);
                end
                VERIFY: if (dec.bit_en) begin
                    cnt_n = check ? '0 : cnt + CNT_W'(1);
                    if (check && hv) begin
                        hits_n = hits_inc;
                        misses_n = '0;
                        st_n = hits_inc >= vn ? LOCK : VERIFY;
                    end else if (check) st_n = SEARCH;
                end
                LOCK: if (dec.bit_en) begin
                    cnt_n = check ? '0 : cnt + CNT_W'(1);
                    strobe_n = check;
                    if (check) begin
                        misses_n = hv ? '0 : misses_inc;
                        if (!hv && misses_inc >= fn) begin
                            st_n = SEARCH;
                            misses_n = '0;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            st <= IDLE;
            hyp <= '0;
            cnt <= '0;
            hits <= '0;
            misses <= '0;
            frame_strobe <= 1'b0;
        end else begin
            st <= st_n;
            hyp <= hyp_n;
            cnt <= cnt_n;
            hits <= hits_n;
            misses <= misses_n;
            frame_strobe <= strobe_n;
        end
    end
endmodule

// File: tb/tb_decoder_sync_ctrl.sv
// tb_decoder_sync_ctrl: directed closed-loop bench with a swap/invert channel model
module tb_decoder_sync_ctrl;
    logic clk, rs, ctrl_en, locked, strobe;
    logic [31:0] sync_word, sync_mask;
    logic [2:0] max_err;
    logic [15:0] frame_len, search_limit;
    logic [3:0] verify_n, flywheel_n;
    logic [1:0] st, need;
    logic [31:0] sw_const;
    logic strm [0:8191];
    int wr, rd, total, passed, fails;

    decoder_sync_ctrl_if dif();

    decoder_sync_ctrl dut (
        .clk(clk), .rs(rs), .dec(dif.slave), .ctrl_en(ctrl_en),
        .sync_word(sync_word), .sync_mask(sync_mask), .max_err(max_err),
        .frame_len(frame_len), .search_limit(search_limit),
        .verify_n(verify_n), .flywheel_n(flywheel_n),
        .locked(locked), .frame_strobe(strobe), .state(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_rand(input int n);
        for (int i = 0; i < n; i++) begin
            strm[wr] = 1'($urandom);
            wr++;
        end
    endtask

    // first e bits at positions 0,3,6.. are flipped to inject exactly e errors
    task automatic put_sync(input int e);
        for (int p = 0; p < 32; p++) begin
            strm[wr] = sw_const[31-p] ^ ((p % 3 == 0) && (p / 3 < e));
            wr++;
        end
    endtask

    // channel: a wrong swap exchanges bit pairs, a wrong inversion flips every bit
    task automatic send();
        logic s, v;
        s = dif.swap ^ need[1];
        v = dif.data_inv ^ need[0];
        dif.bit_in = strm[s ? (rd ^ 1) : rd] ^ v;
        dif.bit_en = 1'b1;
        rd++;
        @(posedge clk);
        #1;
        dif.bit_en = 1'b0;
    endtask

    task automatic play(input int n);
        repeat (n) send();
    endtask

    task automatic tick();
        dif.bit_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0; wr = 0; rd = 0;
        sw_const = 32'h1ACFFC1D;
        need = 2'b00;
        rs = 1'b1; ctrl_en = 1'b0;
        sync_word = sw_const; sync_mask = '1; max_err = 3'd0;
        frame_len = 16'd256; search_limit = 16'd0; verify_n = 4'd3; flywheel_n = 4'd2;
        dif.bit_en = 1'b0; dif.bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_hyp", {dif.swap, dif.data_inv}, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_strobe", 32'(strobe), 32'd0);
        rs = 1'b0;
        ctrl_en = 1'b1;
        tick();
        chk("idle_to_search", 32'(st), 32'd1);
        put_rand(100); put_sync(0);
        for (int i = 0; i < 3; i++) begin put_rand(224); put_sync(0); end
        put_rand(224); put_sync(2);
        put_rand(224); put_sync(3);
        put_rand(224); put_sync(3);
        play(100); chk("search_rand", 32'(st), 32'd1);
        play(31);  chk("search_pre_sync", 32'(st), 32'd1);
        play(1);   chk("first_sync_verify", 32'(st), 32'd2);
        play(256); chk("second_sync_verify", 32'(st), 32'd2);
        play(256); chk("third_sync_lock", 32'(st), 32'd3);
        chk("locked_high", 32'(locked), 32'd1);
        chk("no_strobe_on_lock_entry", 32'(strobe), 32'd0);
        play(255); chk("strobe_before_end", 32'(strobe), 32'd0);
        play(1);   chk("strobe_at_end", 32'(strobe), 32'd1);
        play(1);   chk("strobe_one_clk", 32'(strobe), 32'd0);
        max_err = 3'd2;
        play(254); chk("lock_hold", 32'(st), 32'd3);
        play(1);   chk("two_err_strobe", 32'(strobe), 32'd1);
        chk("two_err_hit_lock", 32'(st), 32'd3);
        play(256); chk("miss1_strobe", 32'(strobe), 32'd1);
        chk("miss1_still_lock", 32'(st), 32'd3);
        play(256); chk("miss2_strobe", 32'(strobe), 32'd1);
        chk("miss2_search", 32'(st), 32'd1);
        chk("miss2_unlocked", 32'(locked), 32'd0);
        chk("miss2_hyp_kept", {dif.swap, dif.data_inv}, 32'd0);
        max_err = 3'd0;
        put_rand(600); play(600);
        chk("limit0_state", 32'(st), 32'd1);
        chk("limit0_hyp", {dif.swap, dif.data_inv}, 32'd0);
        ctrl_en = 1'b0;
        tick();
        chk("disable_idle", 32'(st), 32'd0);
        search_limit = 16'd300;
        need = 2'b10;
        ctrl_en = 1'b1;
        tick();
        chk("reenable_search", 32'(st), 32'd1);
        put_rand(700); put_sync(0);
        put_rand(224); put_sync(0);
        put_rand(224); put_sync(0);
        play(299); chk("hyp_before_timeout", {dif.swap, dif.data_inv}, 32'd0);
        play(1);   chk("hyp_step_01", {dif.swap, dif.data_inv}, 32'd1);
        play(299); chk("hyp_hold_01", {dif.swap, dif.data_inv}, 32'd1);
        play(1);   chk("hyp_step_10", {dif.swap, dif.data_inv}, 32'd2);
        play(132); chk("amb_verify", 32'(st), 32'd2);
        play(512); chk("amb_lock", 32'(st), 32'd3);
        chk("amb_hyp", {dif.swap, dif.data_inv}, 32'd2);
        ctrl_en = 1'b0;
        tick();
        chk("off_idle", 32'(st), 32'd0);
        chk("off_unlocked", 32'(locked), 32'd0);
        chk("off_hyp_held", {dif.swap, dif.data_inv}, 32'd2);
        ctrl_en = 1'b1;
        tick();
        chk("on_search", 32'(st), 32'd1);
        put_rand(100); put_sync(0); put_rand(256);
        play(132); chk("false_hit_verify", 32'(st), 32'd2);
        play(255); chk("verify_ignore_off_check", 32'(st), 32'd2);
        play(1);   chk("verify_fail_search", 32'(st), 32'd1);
        chk("verify_fail_hyp", {dif.swap, dif.data_inv}, 32'd2);
        put_rand(100); put_sync(0);
        play(132); chk("pre_reset_verify", 32'(st), 32'd2);
        #2 rs = 1'b1;
        #1;
        chk("async_rst_state", 32'(st), 32'd0);
        chk("async_rst_hyp", {dif.swap, dif.data_inv}, 32'd0);
        chk("async_rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1 rs = 1'b0;
        tick();
        chk("post_rst_search", 32'(st), 32'd1);
        put_rand(700); put_sync(0);
        put_rand(224); put_sync(0);
        put_rand(224); put_sync(0);
        play(600); chk("post_rst_hyp", {dif.swap, dif.data_inv}, 32'd2);
        play(644); chk("post_rst_lock", 32'(st), 32'd3);
        ctrl_en = 1'b0;
        tick();
        frame_len = 16'd10;
        verify_n = 4'd0;
        ctrl_en = 1'b1;
        tick();
        put_rand(100);
        repeat (4) put_sync(0);
        play(132); chk("short_frame_verify", 32'(st), 32'd2);
        play(31);  chk("short_frame_no_early_check", 32'(st), 32'd2);
        play(1);   chk("verify_n0_lock", 32'(st), 32'd3);
        play(31);  chk("short_strobe_off", 32'(strobe), 32'd0);
        play(1);   chk("short_strobe_on", 32'(strobe), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
